// File: rtl/spi_arbiter_if.sv
// Handshake bundle between requesters, spi_arbiter and spi_core.
// slave is the arbiter view; master is the requester/core view.
interface spi_arbiter_if #(
  parameter int N_REQ   = 2,
  parameter int D_WIDTH = 8,
  parameter int IDX_W   = 1
);
  logic [N_REQ-1:0]         req_valid;
  logic [N_REQ*D_WIDTH-1:0] req_data;
  logic [N_REQ-1:0]         req_last;
  logic [N_REQ-1:0]         req_ready;
  logic [N_REQ-1:0]         grant;
  logic                     rsp_valid;
  logic [D_WIDTH-1:0]       rsp_data;
  logic [IDX_W-1:0]         rsp_id;
  logic                     core_enable;
  logic                     core_cont;
  logic [D_WIDTH-1:0]       core_tx_data;
  logic                     core_busy;
  logic [D_WIDTH-1:0]       core_rx_data;
  logic                     timeout_err;

  modport slave (
    input  req_valid, req_data, req_last,
    input  core_busy, core_rx_data,
    output req_ready, grant,
    output rsp_valid, rsp_data, rsp_id,
    output core_enable, core_cont, core_tx_data,
    output timeout_err
  );

  modport master (
    output req_valid, req_data, req_last,
    output core_busy, core_rx_data,
    input  req_ready, grant,
    input  rsp_valid, rsp_data, rsp_id,
    input  core_enable, core_cont, core_tx_data,
    input  timeout_err
  );
endinterface

// File: rtl/spi_arbiter.sv
// Round-robin, burst-locked arbiter sharing one spi_core.
// Optional watchdog enabled by defining SPI_ARB_TIMEOUT_EN.
module spi_arbiter #(
  parameter int N_REQ   = 2,
  parameter int D_WIDTH = 8,
  parameter int IDX_W   = 1
) (
  input logic           clk,
  input logic           reset,
  spi_arbiter_if.slave  bus
);

  typedef enum logic [2:0] {
    IDLE, LOAD, START, WAIT_BUSY, XFER, HOLD
  } state_e;

  state_e state_q, state_d;

  logic [IDX_W-1:0]   ptr_q, ptr_d;
  logic [IDX_W-1:0]   own_q, own_d;
  logic [IDX_W-1:0]   own_nx, pick;
  logic               found;
  logic [N_REQ-1:0]   grant_q, grant_d;
  logic [N_REQ-1:0]   ready_q, ready_d;
  logic               last_q, last_d;
  logic               cont_q, cont_d;
  logic               en_q, en_d;
  logic               rv_q, rv_d;
  logic [D_WIDTH-1:0] tx_q, tx_d;
  logic [D_WIDTH-1:0] rd_q, rd_d;
  logic [IDX_W-1:0]   rid_q, rid_d;
  logic               own_vld, own_lst;
  logic [D_WIDTH-1:0] own_dat;

`ifdef SPI_ARB_TIMEOUT_EN
  logic [7:0] wd_q, wd_d;
  logic       err_q, err_d;
`endif

  assign own_vld = bus.req_valid[own_q];
  assign own_lst = bus.req_last[own_q];
  assign own_dat =
    bus.req_data[int'(own_q)*D_WIDTH +: D_WIDTH];

  assign own_nx = (int'(own_q) == N_REQ - 1) ?
                  '0 : own_q + 1'b1;

  // First requester at or above the pointer, wrapping.
  always_comb begin : pick_p
    int j;
    found = 1'b0;
    pick  = '0;
    j     = 0;
    for (int k = 0; k < N_REQ; k++) begin
      j = int'(ptr_q) + k;
      if (j >= N_REQ) j = j - N_REQ;
      if (!found && bus.req_valid[j]) begin
        found = 1'b1;
        pick  = IDX_W'(j);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    own_d   = own_q;
    grant_d = grant_q;
    ready_d = '0;
    last_d  = last_q;
    cont_d  = cont_q;
    en_d    = 1'b0;
    rv_d    = 1'b0;
    tx_d    = tx_q;
    rd_d    = rd_q;
    rid_d   = rid_q;
`ifdef SPI_ARB_TIMEOUT_EN
    err_d   = err_q;
    wd_d    = '0;
`endif
    unique case (state_q)
      IDLE: begin
        cont_d = 1'b0;
        if (found) begin
          own_d       = pick;
          grant_d     = '0;
          grant_d[pick] = 1'b1;
          state_d     = LOAD;
        end
      end
      LOAD: begin
        tx_d    = own_dat;
        last_d  = own_lst;
        cont_d  = ~own_lst;
        ready_d = grant_q;
        en_d    = 1'b1;
        state_d = START;
      end
      START: state_d = WAIT_BUSY;
      WAIT_BUSY: begin
        if (bus.core_busy) state_d = XFER;
      end
      XFER: begin
        if (!bus.core_busy) begin
          rd_d  = bus.core_rx_data;
          rid_d = own_q;
          rv_d  = 1'b1;
          if (last_q) begin
            grant_d = '0;
            cont_d  = 1'b0;
            ptr_d   = own_nx;
            state_d = IDLE;
          end else begin
            state_d = HOLD;
          end
        end
      end
      HOLD: begin
        if (own_vld) state_d = LOAD;
      end
      default: state_d = IDLE;
    endcase
`ifdef SPI_ARB_TIMEOUT_EN
    // Watchdog only runs while parked in a waiting state.
    if (state_q == WAIT_BUSY || state_q == HOLD) begin
      wd_d = wd_q + 8'd1;
      if (wd_d == 8'hFF && state_d == state_q) begin
        err_d   = 1'b1;
        grant_d = '0;
        cont_d  = 1'b0;
        ptr_d   = own_nx;
        state_d = IDLE;
      end
    end
    if (state_d != state_q) wd_d = '0;
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      own_q   <= '0;
      grant_q <= '0;
      ready_q <= '0;
      last_q  <= 1'b0;
      cont_q  <= 1'b0;
      en_q    <= 1'b0;
      rv_q    <= 1'b0;
      tx_q    <= '0;
      rd_q    <= '0;
      rid_q   <= '0;
`ifdef SPI_ARB_TIMEOUT_EN
      wd_q    <= '0;
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      own_q   <= own_d;
      grant_q <= grant_d;
      ready_q <= ready_d;
      last_q  <= last_d;
      cont_q  <= cont_d;
      en_q    <= en_d;
      rv_q    <= rv_d;
      tx_q    <= tx_d;
      rd_q    <= rd_d;
      rid_q   <= rid_d;
`ifdef SPI_ARB_TIMEOUT_EN
      wd_q    <= wd_d;
      err_q   <= err_d;
`endif
    end
  end

  assign bus.req_ready    = ready_q;
  assign bus.grant        = grant_q;
  assign bus.rsp_valid    = rv_q;
  assign bus.rsp_data     = rd_q;
  assign bus.rsp_id       = rid_q;
  assign bus.core_enable  = en_q;
  assign bus.core_cont    = cont_q;
  assign bus.core_tx_data = tx_q;
`ifdef SPI_ARB_TIMEOUT_EN
  assign bus.timeout_err  = err_q;
`else
  assign bus.timeout_err  = 1'b0;
`endif

endmodule

// File: tb/tb_spi_arbiter.sv
// Directed bench for spi_arbiter with a simple spi_core model.
// Core returns tx ^ 8'h99 after an 8-cycle busy window.
module tb_spi_arbiter;

  logic clk;
  logic reset;
  logic dead;
  int   cyc;
  int   checks;
  int   errors;

  spi_arbiter_if #(.N_REQ(2), .D_WIDTH(8), .IDX_W(1)) bus ();

  spi_arbiter #(.N_REQ(2), .D_WIDTH(8), .IDX_W(1)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  logic [8:0] srcq [2][$];
  logic [8:0] rspq [$];
  logic [8:0] enq  [$];
  int         glog [$];
  int         glog_rsp [$];
  int         rdycnt [2];
  int         c_valid0, c_ready0, c_fall, c_rsp, c_en;
  int         cc;
  logic       pv0;
  logic [1:0] pg;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    cyc = 0;
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  // Requesters: present queue head, pop on observed ready.
  initial begin
    bus.req_valid = '0;
    bus.req_data  = '0;
    bus.req_last  = '0;
    pv0 = 1'b0;
    c_valid0 = 0;
    forever begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        if (bus.req_ready[i] && srcq[i].size() > 0)
          void'(srcq[i].pop_front());
        if (srcq[i].size() > 0) begin
          bus.req_valid[i] = 1'b1;
          bus.req_data[i*8 +: 8] = srcq[i][0][7:0];
          bus.req_last[i] = srcq[i][0][8];
        end else begin
          bus.req_valid[i] = 1'b0;
        end
      end
      if (bus.req_valid[0] && !pv0) c_valid0 = cyc;
      pv0 = bus.req_valid[0];
    end
  end

  // spi_core model.
  initial begin
    bus.core_busy    = 1'b0;
    bus.core_rx_data = '0;
    cc = 0;
    c_fall = 0;
    forever begin
      @(negedge clk);
      if (reset) begin
        bus.core_busy = 1'b0;
        cc = 0;
      end else if (cc > 0) begin
        cc--;
        if (cc == 0) begin
          bus.core_busy = 1'b0;
          c_fall = cyc;
        end else begin
          bus.core_busy = 1'b1;
        end
      end else if (bus.core_enable && !dead) begin
        bus.core_rx_data = bus.core_tx_data ^ 8'h99;
        cc = 9;
      end
    end
  end

  // Monitor.
  initial begin
    pg = '0;
    c_ready0 = 0;
    c_rsp = 0;
    c_en = 0;
    forever begin
      @(negedge clk);
      if (bus.rsp_valid) begin
        rspq.push_back({bus.rsp_id, bus.rsp_data});
        c_rsp = cyc;
      end
      if (bus.core_enable) begin
        enq.push_back({bus.core_cont, bus.core_tx_data});
        c_en = cyc;
      end
      for (int i = 0; i < 2; i++)
        if (bus.req_ready[i]) rdycnt[i]++;
      if (bus.req_ready[0]) c_ready0 = cyc;
      if (bus.grant != pg && bus.grant != 2'b00) begin
        glog.push_back(bus.grant[1] ? 1 : 0);
        glog_rsp.push_back(rspq.size());
      end
      pg = bus.grant;
    end
  end

  task automatic clear_logs();
    srcq[0].delete();
    srcq[1].delete();
    rspq.delete();
    enq.delete();
    glog.delete();
    glog_rsp.delete();
    rdycnt[0] = 0;
    rdycnt[1] = 0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    dead  = 1'b0;
    @(negedge clk);
    clear_logs();
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic wait_rsp(input int n);
    int t;
    t = 0;
    while (rspq.size() < n && t < 400) begin
      @(negedge clk);
      t++;
    end
    if (rspq.size() < n) begin
      checks++;
      errors++;
      $display("FAIL wait_rsp: got %0d rsp, need %0d",
               rspq.size(), n);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    dead  = 1'b0;
    repeat (3) @(negedge clk);
    clear_logs();
    checks++;
    if ({bus.grant, bus.req_ready, bus.rsp_valid,
         bus.core_enable, bus.core_cont,
         bus.timeout_err} !== 8'h00) begin
      errors++;
      $display("FAIL reset_ctl: got %b exp 0",
               {bus.grant, bus.req_ready, bus.rsp_valid,
                bus.core_enable, bus.core_cont,
                bus.timeout_err});
    end
    checks++;
    if ({bus.core_tx_data, bus.rsp_data, bus.rsp_id}
        !== 17'h0) begin
      errors++;
      $display("FAIL reset_data: got %h exp 0",
               {bus.core_tx_data, bus.rsp_data, bus.rsp_id});
    end
    reset = 1'b0;
    repeat (5) @(negedge clk);
    checks++;
    if (bus.grant !== 2'b00 || enq.size() !== 0) begin
      errors++;
      $display("FAIL idle_noreq: grant %b en %0d exp 0 0",
               bus.grant, enq.size());
    end
  endtask

  task automatic test_single();
    do_reset();
    srcq[0].push_back({1'b1, 8'hA5});
    wait_rsp(1);
    repeat (4) @(negedge clk);
    checks++;
    if (enq.size() !== 1 || enq[0] !== {1'b0, 8'hA5}) begin
      errors++;
      $display("FAIL single_en: got n=%0d %h exp 1 0a5",
               enq.size(), enq[0]);
    end
    checks++;
    if (rdycnt[0] !== 1 || rdycnt[1] !== 0) begin
      errors++;
      $display("FAIL single_ready: got %0d/%0d exp 1/0",
               rdycnt[0], rdycnt[1]);
    end
    checks++;
    if (rspq[0] !== {1'b0, 8'h3C}) begin
      errors++;
      $display("FAIL single_rsp: got %h exp 03c", rspq[0]);
    end
    checks++;
    if (bus.grant !== 2'b00) begin
      errors++;
      $display("FAIL single_grant: got %b exp 00", bus.grant);
    end
    checks++;
    if (c_ready0 - c_valid0 !== 2) begin
      errors++;
      $display("FAIL lat_ready: got %0d exp 2",
               c_ready0 - c_valid0);
    end
    checks++;
    if (c_rsp - c_fall !== 1) begin
      errors++;
      $display("FAIL lat_rsp: got %0d exp 1", c_rsp - c_fall);
    end
  endtask

  task automatic test_round_robin();
    logic [8:0] exp_r [4];
    int         exp_g [4];
    reset = 1'b1;
    dead  = 1'b0;
    @(negedge clk);
    clear_logs();
    srcq[0].push_back({1'b1, 8'h10});
    srcq[0].push_back({1'b1, 8'h11});
    srcq[1].push_back({1'b1, 8'h20});
    srcq[1].push_back({1'b1, 8'h21});
    @(negedge clk);
    reset = 1'b0;
    exp_r = '{9'h089, 9'h1B9, 9'h088, 9'h1B8};
    exp_g = '{0, 1, 0, 1};
    wait_rsp(4);
    repeat (4) @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (glog[k] !== exp_g[k] || rspq[k] !== exp_r[k]) begin
        errors++;
        $display("FAIL rr_%0d: grant %0d rsp %h exp %0d %h",
                 k, glog[k], rspq[k], exp_g[k], exp_r[k]);
      end
    end
    checks++;
    if (rdycnt[0] !== 2 || rdycnt[1] !== 2) begin
      errors++;
      $display("FAIL rr_ready: got %0d/%0d exp 2/2",
               rdycnt[0], rdycnt[1]);
    end
  endtask

  task automatic test_burst();
    logic [8:0] exp_e [4];
    logic [8:0] exp_r [4];
    do_reset();
    srcq[0].push_back({1'b0, 8'h01});
    srcq[0].push_back({1'b0, 8'h02});
    srcq[0].push_back({1'b1, 8'h03});
    srcq[1].push_back({1'b1, 8'h44});
    exp_e = '{9'h101, 9'h102, 9'h003, 9'h044};
    exp_r = '{9'h098, 9'h09B, 9'h09A, 9'h1DD};
    wait_rsp(4);
    repeat (4) @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (enq[k] !== exp_e[k] || rspq[k] !== exp_r[k]) begin
        errors++;
        $display("FAIL burst_%0d: en %h rsp %h exp %h %h",
                 k, enq[k], rspq[k], exp_e[k], exp_r[k]);
      end
    end
    checks++;
    if (glog.size() !== 2 || glog[1] !== 1 ||
        glog_rsp[1] !== 3) begin
      errors++;
      $display("FAIL burst_lock: n=%0d g1=%0d rsp_at=%0d exp 2 1 3",
               glog.size(), glog[1], glog_rsp[1]);
    end
  endtask

  task automatic test_owner_gap();
    do_reset();
    srcq[0].push_back({1'b0, 8'h55});
    srcq[1].push_back({1'b1, 8'h77});
    wait_rsp(1);
    repeat (20) @(negedge clk);
    checks++;
    if (bus.grant !== 2'b01 || bus.core_cont !== 1'b1) begin
      errors++;
      $display("FAIL gap_hold: grant %b cont %b exp 01 1",
               bus.grant, bus.core_cont);
    end
    checks++;
    if (enq.size() !== 1 || rdycnt[1] !== 0 ||
        rspq.size() !== 1) begin
      errors++;
      $display("FAIL gap_idle: en %0d rdy1 %0d rsp %0d exp 1 0 1",
               enq.size(), rdycnt[1], rspq.size());
    end
    srcq[0].push_back({1'b1, 8'h66});
    wait_rsp(3);
    repeat (4) @(negedge clk);
    checks++;
    if (rspq[0] !== 9'h0CC || rspq[1] !== 9'h0FF ||
        rspq[2] !== 9'h1EE) begin
      errors++;
      $display("FAIL gap_rsp: got %h %h %h exp 0cc 0ff 1ee",
               rspq[0], rspq[1], rspq[2]);
    end
    checks++;
    if (enq[1] !== {1'b0, 8'h66}) begin
      errors++;
      $display("FAIL gap_cont: got %h exp 066", enq[1]);
    end
  endtask

  task automatic test_reset_mid();
    int t;
    do_reset();
    srcq[0].push_back({1'b1, 8'h5A});
    wait_rsp(1);
    srcq[1].push_back({1'b0, 8'h33});
    t = 0;
    while (!bus.core_busy && t < 100) begin
      @(negedge clk);
      t++;
    end
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if ({bus.grant, bus.req_ready, bus.rsp_valid,
         bus.core_enable, bus.core_cont} !== 7'h00 ||
        bus.core_tx_data !== 8'h00) begin
      errors++;
      $display("FAIL mid_reset: got %b tx %h exp 0 00",
               {bus.grant, bus.req_ready, bus.rsp_valid,
                bus.core_enable, bus.core_cont},
               bus.core_tx_data);
    end
    clear_logs();
    srcq[0].push_back({1'b1, 8'h0A});
    srcq[1].push_back({1'b1, 8'h0B});
    @(negedge clk);
    reset = 1'b0;
    wait_rsp(2);
    checks++;
    if (glog[0] !== 0 || rspq[0] !== 9'h093 ||
        rspq[1] !== 9'h192) begin
      errors++;
      $display("FAIL mid_after: g0 %0d rsp %h %h exp 0 093 192",
               glog[0], rspq[0], rspq[1]);
    end
  endtask

`ifdef SPI_ARB_TIMEOUT_EN
  task automatic test_timeout();
    int t;
    do_reset();
    dead = 1'b1;
    srcq[0].push_back({1'b1, 8'hC3});
    t = 0;
    while (enq.size() == 0 && t < 50) begin
      @(negedge clk);
      t++;
    end
    t = 0;
    while (!bus.timeout_err && t < 400) begin
      @(negedge clk);
      t++;
    end
    checks++;
    if (cyc - c_en !== 256) begin
      errors++;
      $display("FAIL tmo_time: got %0d exp 256", cyc - c_en);
    end
    checks++;
    if (bus.grant !== 2'b00 || bus.core_cont !== 1'b0) begin
      errors++;
      $display("FAIL tmo_grant: grant %b cont %b exp 00 0",
               bus.grant, bus.core_cont);
    end
    repeat (5) @(negedge clk);
    checks++;
    if (bus.timeout_err !== 1'b1 || rspq.size() !== 0) begin
      errors++;
      $display("FAIL tmo_sticky: err %b rsp %0d exp 1 0",
               bus.timeout_err, rspq.size());
    end
    dead = 1'b0;
  endtask
`endif

  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b1;
    dead   = 1'b0;
    rdycnt[0] = 0;
    rdycnt[1] = 0;
    test_reset();
    test_single();
    test_round_robin();
    test_burst();
    test_owner_gap();
    test_reset_mid();
`ifdef SPI_ARB_TIMEOUT_EN
    test_timeout();
`endif
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
